cmp_share_arbiter: RTL and testbench



---
 rtl/cmp_share_arbiter_if.sv | 31 +++
 rtl/cmp_share_arbiter.sv | 143 ++++++++++++++
 tb/tb_cmp_share_arbiter.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/cmp_share_arbiter_if.sv
// Request/operand and grant/response bundle for the shared comparator.
// Clients use the master modport; the arbiter uses the slave modport.
interface cmp_share_arbiter_if #(
    parameter int N = 4,
    parameter int W = 4
);
    localparam int IDW = $clog2(N);

    logic [N-1:0]   req;
    logic [N*W-1:0] a_flat;
    logic [N*W-1:0] b_flat;
    logic [N-1:0]   gnt;
    logic           busy;
    logic           rsp_valid;
    logic [IDW-1:0] rsp_id;
    logic           rsp_gt;
    logic           rsp_lt;
    logic           rsp_eq;

    modport master (
        output req, a_flat, b_flat,
        input  gnt, busy, rsp_valid, rsp_id,
        input  rsp_gt, rsp_lt, rsp_eq
    );

    modport slave (
        input  req, a_flat, b_flat,
        output gnt, busy, rsp_valid, rsp_id,
        output rsp_gt, rsp_lt, rsp_eq
    );
endinterface

// File: rtl/cmp_share_arbiter.sv
// Round-robin arbiter sharing one W-bit magnitude comparator among N clients.
// Optional macro CMP_SIGNED_EN selects two's-complement ordering for gt/lt.
module cmp_share_arbiter #(
    parameter int N = 4,
    parameter int W = 4
) (
    input logic              clk,
    input logic              rst_n,
    cmp_share_arbiter_if.slave bus
);
    localparam int IDW = $clog2(N);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [IDW-1:0] last_q, last_d;
    logic [IDW-1:0] win_q, win_d;
    logic [W-1:0]   op_a_q, op_a_d;
    logic [W-1:0]   op_b_q, op_b_d;
    logic [N-1:0]   gnt_q, gnt_d;
    logic           busy_q, busy_d;
    logic           vld_q, vld_d;
    logic [IDW-1:0] rid_q, rid_d;
    logic           gt_q, gt_d;
    logic           lt_q, lt_d;
    logic           eq_q, eq_d;

    logic           pick_ok;
    logic [IDW-1:0] pick_id;
    logic           a_gt, a_lt, a_eq;

    // Search last+1, last+2, ... mod N; scanning backwards leaves the
    // nearest requester as the final assignment.
    function automatic logic [IDW:0] rr_pick(
        input logic [N-1:0]   r,
        input logic [IDW-1:0] last
    );
        logic [IDW:0] res;
        int           idx;
        res = '0;
        for (int k = N; k >= 1; k--) begin
            idx = (int'(last) + k) % N;
            if (r[idx]) res = {1'b1, IDW'(idx)};
        end
        return res;
    endfunction

    assign {pick_ok, pick_id} = rr_pick(bus.req, last_q);

`ifdef CMP_SIGNED_EN
    assign a_gt = $signed(op_a_q) > $signed(op_b_q);
    assign a_lt = $signed(op_a_q) < $signed(op_b_q);
`else
    assign a_gt = op_a_q > op_b_q;
    assign a_lt = op_a_q < op_b_q;
`endif
    assign a_eq = op_a_q == op_b_q;

    // Next-state and registered-output logic of the IDLE/CMP/RESP sequencer.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        win_d   = win_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        gnt_d   = '0;
        vld_d   = 1'b0;
        rid_d   = rid_q;
        gt_d    = gt_q;
        lt_d    = lt_q;
        eq_d    = eq_q;
        unique case (state_q)
            IDLE: begin
                if (pick_ok) begin
                    win_d   = pick_id;
                    op_a_d  = bus.a_flat[int'(pick_id)*W +: W];
                    op_b_d  = bus.b_flat[int'(pick_id)*W +: W];
                    gnt_d   = N'(1) << pick_id;
                    state_d = CMP;
                end
            end
            CMP: begin
                gt_d    = a_gt;
                lt_d    = a_lt;
                eq_d    = a_eq;
                vld_d   = 1'b1;
                rid_d   = win_q;
                last_d  = win_q;
                state_d = RESP;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = state_d != IDLE;
    end

    // State and output registers; reset drops any in-flight transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            last_q  <= IDW'(N - 1);
            win_q   <= '0;
            op_a_q  <= '0;
            op_b_q  <= '0;
            gnt_q   <= '0;
            busy_q  <= 1'b0;
            vld_q   <= 1'b0;
            rid_q   <= '0;
            gt_q    <= 1'b0;
            lt_q    <= 1'b0;
            eq_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            win_q   <= win_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            gnt_q   <= gnt_d;
            busy_q  <= busy_d;
            vld_q   <= vld_d;
            rid_q   <= rid_d;
            gt_q    <= gt_d;
            lt_q    <= lt_d;
            eq_q    <= eq_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.busy      = busy_q;
    assign bus.rsp_valid = vld_q;
    assign bus.rsp_id    = rid_q;
    assign bus.rsp_gt    = gt_q;
    assign bus.rsp_lt    = lt_q;
    assign bus.rsp_eq    = eq_q;
endmodule

// File: tb/tb_cmp_share_arbiter.sv
// Directed bench for cmp_share_arbiter (N=4, W=4).
// Inputs change and outputs are sampled on the falling edge.
module tb_cmp_share_arbiter;
    localparam int N = 4;
    localparam int W = 4;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_fail;

    cmp_share_arbiter_if #(.N(N), .W(W)) bus ();

    cmp_share_arbiter #(.N(N), .W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(
        input string       tag,
        input logic [31:0] got,
        input logic [31:0] exp
    );
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_ops(
        input int         idx,
        input logic [3:0] a,
        input logic [3:0] b
    );
        bus.a_flat[idx*W +: W] = a;
        bus.b_flat[idx*W +: W] = b;
    endtask

    // One isolated transaction starting from IDLE at a falling edge.
    task automatic txn(
        input string      tag,
        input int         idx,
        input logic [3:0] a,
        input logic [3:0] b,
        input bit         scramble,
        input logic       egt,
        input logic       elt,
        input logic       eeq
    );
        bus.req = 4'b0001 << idx;
        set_ops(idx, a, b);
        @(negedge clk);
        check({tag, ".gnt"}, 32'(bus.gnt), 32'(4'b0001 << idx));
        check({tag, ".busy1"}, 32'(bus.busy), 32'd1);
        bus.req = '0;
        if (scramble) set_ops(idx, ~a, ~b);
        @(negedge clk);
        check({tag, ".vld"}, 32'(bus.rsp_valid), 32'd1);
        check({tag, ".id"}, 32'(bus.rsp_id), 32'(idx));
        check({tag, ".gt"}, 32'(bus.rsp_gt), 32'(egt));
        check({tag, ".lt"}, 32'(bus.rsp_lt), 32'(elt));
        check({tag, ".eq"}, 32'(bus.rsp_eq), 32'(eeq));
        check({tag, ".gnt0"}, 32'(bus.gnt), 32'd0);
        @(negedge clk);
        check({tag, ".busy0"}, 32'(bus.busy), 32'd0);
        check({tag, ".vld0"}, 32'(bus.rsp_valid), 32'd0);
        check({tag, ".hold"}, 32'(bus.rsp_id), 32'(idx));
    endtask

    initial begin
        int pulses;
        n_chk      = 0;
        n_fail     = 0;
        rst_n      = 1'b0;
        bus.req    = '0;
        bus.a_flat = '0;
        bus.b_flat = '0;
        repeat (2) @(negedge clk);
        check("rst.gnt", 32'(bus.gnt), 32'd0);
        check("rst.busy", 32'(bus.busy), 32'd0);
        check("rst.vld", 32'(bus.rsp_valid), 32'd0);
        check("rst.id", 32'(bus.rsp_id), 32'd0);
        check("rst.cmp", 32'({bus.rsp_gt, bus.rsp_lt, bus.rsp_eq}), 32'd0);

        // Single request from requester 2: 6 > 3.
        rst_n = 1'b1;
        txn("single", 2, 4'b0110, 4'b0011, 1'b0, 1'b1, 1'b0, 1'b0);

        // Reset while in CMP: no response may follow.
        bus.req = 4'b0001;
        set_ops(0, 4'b0001, 4'b0010);
        @(negedge clk);
        check("midrst.gnt", 32'(bus.gnt), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst.busy", 32'(bus.busy), 32'd0);
        check("midrst.gnt0", 32'(bus.gnt), 32'd0);
        check("midrst.vld", 32'(bus.rsp_valid), 32'd0);
        check("midrst.cmp", 32'({bus.rsp_gt, bus.rsp_lt, bus.rsp_eq}), 32'd0);
        bus.req = '0;
        rst_n   = 1'b1;
        pulses  = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.rsp_valid) pulses++;
        end
        check("midrst.nopulse", 32'(pulses), 32'd0);

        // All four requesting from reset: grants 0,1,2,3,0 every 3 cycles.
        rst_n   = 1'b0;
        bus.req = 4'b1111;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            check($sformatf("rr.gnt%0d", k), 32'(bus.gnt),
                  (k % 3 == 1) ? 32'(4'b0001 << ((k / 3) % 4)) : 32'd0);
        end

        // last=3 after reset, req=1010: 1 then 3 then 1.
        rst_n   = 1'b0;
        bus.req = 4'b1010;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            if (k == 1) check("wrap.g1", 32'(bus.gnt), 32'(4'b0010));
            if (k == 4) check("wrap.g3", 32'(bus.gnt), 32'(4'b1000));
            if (k == 7) check("wrap.g1b", 32'(bus.gnt), 32'(4'b0010));
        end
        bus.req = '0;
        repeat (3) @(negedge clk);
        check("wrap.idle", 32'(bus.busy), 32'd0);

        // Operand boundaries.
        txn("eq", 0, 4'b1010, 4'b1010, 1'b0, 1'b0, 1'b0, 1'b1);
`ifdef CMP_SIGNED_EN
        txn("ext", 3, 4'b1111, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0);
`else
        txn("ext", 3, 4'b1111, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0);
`endif

        // Operands changed after the grant must not matter: 2 < 5.
        txn("late", 1, 4'b0010, 4'b0101, 1'b1, 1'b0, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
